// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: loadable program memory sequenced to the cpu over a valid/ready handshake
module instruction_fetch_unit #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   load_enable,
  input  logic [ADDR_WIDTH-1:0]  load_address,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   cpu_ready,
  input  logic                   jump_enable,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic [INSTR_WIDTH-1:0] current_instruction,
  output logic                   instruction_valid,
  output logic [ADDR_WIDTH-1:0]  program_counter,
  output logic                   busy,
  output logic                   halted
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALTED} state_t;
  state_t state;
  logic read_done;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_data;
  logic load_ok;
  logic is_halt;
  logic [ADDR_WIDTH-1:0] pc_inc;
  assign load_ok = load_enable && (state == IDLE || state == HALTED);
  assign is_halt = current_instruction[INSTR_WIDTH-1 -: 8] == HALT_OPCODE;
  assign pc_inc = program_counter == ADDR_WIDTH'(DEPTH - 1) ? '0 : program_counter + 1'b1;
  assign busy = state == FETCH || state == PRESENT;
  assign halted = state == HALTED;
  always_ff @(posedge clock_in) begin
    if (load_ok) mem[load_address] <= load_data;
    rd_data <= mem[program_counter];
  end
  // FETCH spends one cycle applying the PC and one capturing the registered read data
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= IDLE;
      program_counter <= '0;
      current_instruction <= '0;
      instruction_valid <= 1'b0;
      read_done <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: if (start) begin
          state <= FETCH;
          program_counter <= '0;
          read_done <= 1'b0;
        end
        FETCH: begin
          read_done <= !read_done;
          if (read_done) begin
            current_instruction <= rd_data;
            instruction_valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: if (instruction_valid && cpu_ready) begin
          instruction_valid <= 1'b0;
          read_done <= 1'b0;
          state <= is_halt ? HALTED : FETCH;
          program_counter <= is_halt ? program_counter : jump_enable ? jump_target : pc_inc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenario tasks with hand-computed expected words and PCs
module tb_instruction_fetch_unit;
  logic clock_in = 1'b0;
  logic reset_in = 1'b1, load_enable = 1'b0, start = 1'b0, cpu_ready = 1'b0, jump_enable = 1'b0;
  logic [5:0] load_address = '0, jump_target = '0, program_counter;
  logic [31:0] load_data = '0, current_instruction;
  logic instruction_valid, busy, halted;
  int compared = 0, mismatched = 0;
  bit got;

  always #5 clock_in = ~clock_in;

  instruction_fetch_unit dut (
    .clock_in(clock_in), .reset_in(reset_in), .load_enable(load_enable),
    .load_address(load_address), .load_data(load_data), .start(start),
    .cpu_ready(cpu_ready), .jump_enable(jump_enable), .jump_target(jump_target),
    .current_instruction(current_instruction), .instruction_valid(instruction_valid),
    .program_counter(program_counter), .busy(busy), .halted(halted)
  );

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    load_enable = 1'b1; load_address = a; load_data = d;
    step();
    load_enable = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 8 && !instruction_valid; i++) step();
    ok = instruction_valid;
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 20 && !halted; i++) step();
  endtask

  task automatic accept();
    cpu_ready = 1'b1;
    step();
    cpu_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    step(); step();
    reset_in = 1'b0;
    compared++;
    if ({current_instruction, instruction_valid, program_counter, busy, halted} !== {32'h0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset: ci=%h valid=%b pc=%0d busy=%b halted=%b, want 0/0/0/0/0",
               current_instruction, instruction_valid, program_counter, busy, halted);
    end
  endtask

  task automatic test_run_to_halt();
    load_word(6'd0, 32'h0100_0001);
    load_word(6'd1, 32'h0200_0002);
    load_word(6'd2, 32'hFF00_0000);
    cpu_ready = 1'b1;
    pulse_start();
    compared++;
    if ({busy, instruction_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL start_fetch: busy=%b valid=%b, want busy=1 valid=0", busy, instruction_valid);
    end
    step();
    compared++;
    if (instruction_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_early: valid=%b one edge after start+1, want 0", instruction_valid);
    end
    step();
    compared++;
    if ({instruction_valid, current_instruction, program_counter} !== {1'b1, 32'h0100_0001, 6'd0}) begin
      mismatched++;
      $display("FAIL latency_word0: valid=%b ci=%h pc=%0d, want 1 01000001 0",
               instruction_valid, current_instruction, program_counter);
    end
    step();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0200_0002, 6'd1}) begin
      mismatched++;
      $display("FAIL run_word1: valid=%b ci=%h pc=%0d, want 02000002 pc=1", got, current_instruction, program_counter);
    end
    step();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'hFF00_0000, 6'd2}) begin
      mismatched++;
      $display("FAIL run_word2: valid=%b ci=%h pc=%0d, want ff000000 pc=2", got, current_instruction, program_counter);
    end
    step();
    cpu_ready = 1'b0;
    compared++;
    if ({halted, busy, instruction_valid, current_instruction, program_counter} !== {3'b100, 32'hFF00_0000, 6'd2}) begin
      mismatched++;
      $display("FAIL halt: halted=%b busy=%b valid=%b ci=%h pc=%0d, want 1 0 0 ff000000 2",
               halted, busy, instruction_valid, current_instruction, program_counter);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    wait_valid(got);
    accept();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0200_0002, 6'd1}) begin
      mismatched++;
      $display("FAIL stall_entry: valid=%b ci=%h pc=%0d, want 02000002 pc=1", got, current_instruction, program_counter);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if ({instruction_valid, current_instruction, program_counter} !== {1'b1, 32'h0200_0002, 6'd1}) begin
        mismatched++;
        $display("FAIL stall_hold%0d: valid=%b ci=%h pc=%0d, want 1 02000002 1",
                 i, instruction_valid, current_instruction, program_counter);
      end
    end
    accept();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'hFF00_0000, 6'd2}) begin
      mismatched++;
      $display("FAIL stall_next: valid=%b ci=%h pc=%0d, want ff000000 pc=2", got, current_instruction, program_counter);
    end
    accept();
  endtask

  task automatic test_jump();
    load_word(6'd5, 32'h0500_0005);
    pulse_start();
    wait_valid(got);
    accept();
    wait_valid(got);
    jump_enable = 1'b1; jump_target = 6'd5;
    accept();
    jump_enable = 1'b0;
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0500_0005, 6'd5}) begin
      mismatched++;
      $display("FAIL jump: valid=%b ci=%h pc=%0d, want 05000005 pc=5", got, current_instruction, program_counter);
    end
    jump_enable = 1'b1; jump_target = 6'd9;
    step(); step(); step();
    jump_enable = 1'b0;
    compared++;
    if ({instruction_valid, current_instruction, program_counter} !== {1'b1, 32'h0500_0005, 6'd5}) begin
      mismatched++;
      $display("FAIL jump_no_handshake: valid=%b ci=%h pc=%0d, want 1 05000005 5",
               instruction_valid, current_instruction, program_counter);
    end
  endtask

  task automatic test_reset_mid_run();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    compared++;
    if ({busy, halted, instruction_valid, program_counter, current_instruction} !== {3'b000, 6'd0, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_mid: busy=%b halted=%b valid=%b pc=%0d ci=%h, want idle pc=0 ci=0",
               busy, halted, instruction_valid, program_counter, current_instruction);
    end
    reset_in = 1'b1; start = 1'b1;
    step();
    reset_in = 1'b0; start = 1'b0;
    step();
    compared++;
    if ({busy, instruction_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_wins: busy=%b valid=%b, want 0 0", busy, instruction_valid);
    end
  endtask

  task automatic test_wrap();
    load_word(6'd63, 32'h0300_0003);
    pulse_start();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0100_0001, 6'd0}) begin
      mismatched++;
      $display("FAIL restart_word0: valid=%b ci=%h pc=%0d, want 01000001 pc=0", got, current_instruction, program_counter);
    end
    jump_enable = 1'b1; jump_target = 6'd63;
    accept();
    jump_enable = 1'b0;
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0300_0003, 6'd63}) begin
      mismatched++;
      $display("FAIL jump63: valid=%b ci=%h pc=%0d, want 03000003 pc=63", got, current_instruction, program_counter);
    end
    accept();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0100_0001, 6'd0}) begin
      mismatched++;
      $display("FAIL wrap: valid=%b ci=%h pc=%0d, want 01000001 pc=0", got, current_instruction, program_counter);
    end
  endtask

  task automatic test_load_gating();
    load_word(6'd0, 32'hDEAD_BEEF);
    accept();
    load_word(6'd0, 32'hDEAD_BEEF);
    cpu_ready = 1'b1;
    wait_halted();
    cpu_ready = 1'b0;
    compared++;
    if (halted !== 1'b1) begin
      mismatched++;
      $display("FAIL halt_timeout: halted=%b, want 1", halted);
    end
    pulse_start();
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0100_0001, 6'd0}) begin
      mismatched++;
      $display("FAIL busy_load_ignored: valid=%b ci=%h pc=%0d, want 01000001 pc=0", got, current_instruction, program_counter);
    end
    cpu_ready = 1'b1;
    wait_halted();
    cpu_ready = 1'b0;
    load_enable = 1'b1; load_address = 6'd0; load_data = 32'h0A00_000A; start = 1'b1;
    step();
    load_enable = 1'b0; start = 1'b0;
    wait_valid(got);
    compared++;
    if (!got || {current_instruction, program_counter} !== {32'h0A00_000A, 6'd0}) begin
      mismatched++;
      $display("FAIL reload_start: valid=%b ci=%h pc=%0d, want 0a00000a pc=0", got, current_instruction, program_counter);
    end
  endtask

  initial begin
    test_reset();
    test_run_to_halt();
    test_stall();
    test_jump();
    test_reset_mid_run();
    test_wrap();
    test_load_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
